pixel_reg_array: RTL

Per-column pixel register array directly downstream of the input-buffer interface FSM. Each cycle it executes one `reg_array_cmd`. It can load a POY-tall pixel column from the input buffer, shift the column up by one kernel row, or rebuild the column from an internal line FIFO of reused pixels. The result drives the POY PE rows of the depthwise-conv array, tagged with the current kernel-row index.

---
 rtl/mbn_pkg.sv | 13 +
 rtl/line_fifo.sv | 55 +++++
 rtl/pixel_reg_array.sv | 83 ++++++++
 3 files changed

// File: rtl/mbn_pkg.sv
// mbn_pkg: shared command encoding and default geometry for the pixel register array
package mbn_pkg;
  typedef enum logic [1:0] {
    CMD_BUF   = 2'b00,
    CMD_SHIFT = 2'b01,
    CMD_FIFO  = 2'b10,
    CMD_HOLD  = 2'b11
  } reg_cmd_e;
  localparam int POY_DEF    = 3;
  localparam int KSIZE_DEF  = 3;
  localparam int DW_DEF     = 8;
  localparam int FDEPTH_DEF = 16;
endpackage

// File: rtl/line_fifo.sv
// line_fifo: line buffer of reused pixels with registered read data and error pulses
module line_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_q, full_q, do_push, do_pop;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    do_pop = pop && !empty_q;
    do_push = push && (!full_q || pop);
    ovf = push && full_q && !pop;
    udf = pop && empty_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage is written only on accepted pushes and needs no reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= push_data;
  // pointers, count, flags and read register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_pop) data_q <= mem_q[rd_q];
      cnt_q <= cnt_d;
      empty_q <= cnt_d == '0;
      full_q <= cnt_d == FULL_CNT;
    end
  assign pop_data = data_q;
  assign empty = empty_q;
  assign full = full_q;
endmodule

// File: rtl/pixel_reg_array.sv
// pixel_reg_array: per-column pixel registers feeding the PE rows, with a line FIFO of reused pixels
module pixel_reg_array
  import mbn_pkg::*;
#(
  parameter int POY    = POY_DEF,
  parameter int KSIZE  = KSIZE_DEF,
  parameter int DW     = DW_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_en,
  input  logic [1:0]        reg_array_cmd,
  input  logic [POY*DW-1:0] buf_pix,
  input  logic              fifo_read,
  output logic [POY*DW-1:0] pix_out,
  output logic              pix_vld,
  output logic [3:0]        krow,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              err_ovf,
  output logic              err_udf,
  output logic              err_seq
);
  localparam int W = POY*DW;
  localparam int SW = (POY-1)*DW;
  localparam logic [3:0] KMAX = 4'(KSIZE-1);
  reg_cmd_e cmd;
  logic exec, push, ovf, udf, seq_hit;
  logic [DW-1:0] top;
  logic [W-1:0] pix_q, pix_d, fifo_cat;
  logic [SW-1:0] fifo_q, push_data;
  logic [3:0] krow_q, krow_d;
  logic vld_q, err_ovf_q, err_udf_q, err_seq_q;
  assign cmd = reg_cmd_e'(reg_array_cmd);
  assign top = buf_pix[W-1 -: DW];
  // column rebuilt from reused pixels: FIFO head below, fresh buffer pixel on top
  assign fifo_cat = {top, fifo_q};
  // next column contents, kernel-row tag and FIFO push for the current command
  always_comb begin
    exec = cmd_en && cmd != CMD_HOLD;
    pix_d = !exec ? pix_q : cmd == CMD_BUF ? buf_pix : cmd == CMD_SHIFT ? {top, pix_q[W-1:DW]} : fifo_cat;
    krow_d = !exec ? krow_q : cmd != CMD_SHIFT ? 4'd0 : krow_q == KMAX ? krow_q : krow_q + 4'd1;
    seq_hit = exec && cmd == CMD_SHIFT && krow_q == KMAX;
    push = exec && cmd != CMD_SHIFT;
    push_data = cmd == CMD_BUF ? buf_pix[W-1:DW] : fifo_cat[W-1:DW];
  end
  line_fifo #(.WIDTH(SW), .DEPTH(FDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_read),
    .pop_data  (fifo_q),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .ovf       (ovf),
    .udf       (udf)
  );
  // pixel registers, tag, valid strobe and sticky error flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_q <= '0;
      krow_q <= '0;
      vld_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      krow_q <= krow_d;
      vld_q <= exec;
      err_ovf_q <= err_ovf_q | ovf;
      err_udf_q <= err_udf_q | udf;
      err_seq_q <= err_seq_q | seq_hit;
    end
  assign pix_out = pix_q;
  assign pix_vld = vld_q;
  assign krow = krow_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
  assign err_seq = err_seq_q;
endmodule
